// File: rtl/wb_commit_queue.sv
// Writeback commit queue: four per-lane result FIFOs drained round-robin into one register write per cycle.
// Optional WB_PENDING_EN macro enables the per-query pending-write hazard flags.
module wb_commit_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [3:0]          inValid,
    output logic [3:0]          inReady,
    input  logic [4*ADDR_W-1:0] inAddr,
    input  logic [4*DATA_W-1:0] inData,
    output logic                wbEnable,
    output logic [ADDR_W-1:0]   wbAddr,
    output logic [DATA_W-1:0]   wbData,
    output logic                idle,
    input  logic [4*ADDR_W-1:0] queryAddr,
    output logic [3:0]          pending
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] fifo_addr [4][DEPTH];
    logic [DATA_W-1:0] fifo_data [4][DEPTH];
    logic [PTR_W-1:0]  wr_ptr [4];
    logic [PTR_W-1:0]  rd_ptr [4];
    logic [CNT_W-1:0]  count  [4];
    logic [1:0]        rr_ptr;

    logic [3:0]        nonempty;
    logic [3:0]        push;
    logic [3:0]        pop;
    logic              grant_valid;
    logic [1:0]        grant_lane;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;

    // Ready depends only on registered count, so a same-cycle pop never opens a full lane.
    always_comb begin
        inReady  = '0;
        nonempty = '0;
        push     = '0;
        pop      = '0;
        for (int i = 0; i < 4; i++) begin
            inReady[i]  = (count[i] != CNT_W'(DEPTH));
            nonempty[i] = (count[i] != '0);
            push[i]     = inValid[i] && (count[i] != CNT_W'(DEPTH))
                          && (inAddr[i*ADDR_W +: ADDR_W] != '0);
            pop[i]      = grant_valid && (grant_lane == 2'(i));
        end
    end

    // Scan from the far end so the lane closest to rr_ptr wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_lane  = rr_ptr;
        for (int k = 3; k >= 0; k--) begin
            if (nonempty[rr_ptr + 2'(k)]) begin
                grant_valid = 1'b1;
                grant_lane  = rr_ptr + 2'(k);
            end
        end
    end

    assign head_addr = fifo_addr[grant_lane][rd_ptr[grant_lane]];
    assign head_data = fifo_data[grant_lane][rd_ptr[grant_lane]];
    assign idle      = ~wbEnable & ~|nonempty;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (push[i]) begin
                fifo_addr[i][wr_ptr[i]] <= inAddr[i*ADDR_W +: ADDR_W];
                fifo_data[i][wr_ptr[i]] <= inData[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            rr_ptr   <= 2'd0;
            wbEnable <= 1'b0;
            wbAddr   <= '0;
            wbData   <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (push[i])
                    wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                if (pop[i])
                    rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                if (push[i] && !pop[i])
                    count[i] <= count[i] + CNT_W'(1);
                else if (!push[i] && pop[i])
                    count[i] <= count[i] - CNT_W'(1);
            end
            if (grant_valid) begin
                wbEnable <= 1'b1;
                wbAddr   <= head_addr;
                wbData   <= head_data;
                rr_ptr   <= grant_lane + 2'd1;
            end else begin
                wbEnable <= 1'b0;
            end
        end
    end

`ifdef WB_PENDING_EN
    logic [DEPTH-1:0] entry_valid [4];

    // An entry slot is live when its distance from the read pointer is below the count.
    always_comb begin
        logic [PTR_W-1:0] offs;
        offs = '0;
        for (int l = 0; l < 4; l++) begin
            entry_valid[l] = '0;
            for (int k = 0; k < DEPTH; k++) begin
                offs              = PTR_W'(k) - rd_ptr[l];
                entry_valid[l][k] = ({1'b0, offs} < count[l]);
            end
        end
    end

    always_comb begin
        logic [ADDR_W-1:0] q;
        q       = '0;
        pending = '0;
        for (int j = 0; j < 4; j++) begin
            q = queryAddr[j*ADDR_W +: ADDR_W];
            if (q != '0) begin
                if (wbEnable && (wbAddr == q))
                    pending[j] = 1'b1;
                for (int l = 0; l < 4; l++)
                    for (int k = 0; k < DEPTH; k++)
                        if (entry_valid[l][k] && (fifo_addr[l][k] == q))
                            pending[j] = 1'b1;
            end
        end
    end
`else
    logic unused_query;
    assign unused_query = ^queryAddr;
    assign pending      = 4'b0000;
`endif

endmodule

// File: tb/tb_wb_commit_queue.sv
// Directed self-checking bench for wb_commit_queue: latency, round-robin, backpressure, zero register, reset, pending.
module tb_wb_commit_queue;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

`ifdef WB_PENDING_EN
    localparam logic [3:0] PEND_HIT = 4'b0001;
`else
    localparam logic [3:0] PEND_HIT = 4'b0000;
`endif

    logic                clk;
    logic                rst_n;
    logic [3:0]          inValid;
    logic [3:0]          inReady;
    logic [4*ADDR_W-1:0] inAddr;
    logic [4*DATA_W-1:0] inData;
    logic                wbEnable;
    logic [ADDR_W-1:0]   wbAddr;
    logic [DATA_W-1:0]   wbData;
    logic                idle;
    logic [4*ADDR_W-1:0] queryAddr;
    logic [3:0]          pending;

    int n_checks = 0;
    int n_fail   = 0;

    logic              sb_on = 1'b0;
    logic [31:0]       exp_d [4][16];
    int                sb_head [4];
    int                sb_tail [4];
    int                n_acc = 0;
    int                n_wr  = 0;

    wb_commit_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .inValid   (inValid),
        .inReady   (inReady),
        .inAddr    (inAddr),
        .inData    (inData),
        .wbEnable  (wbEnable),
        .wbAddr    (wbAddr),
        .wbData    (wbData),
        .idle      (idle),
        .queryAddr (queryAddr),
        .pending   (pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_lane(input int l, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        inAddr[l*ADDR_W +: ADDR_W] = a;
        inData[l*DATA_W +: DATA_W] = d;
    endtask

    // Advance one edge and sample 1ns later; scoreboard records handshakes and checks writes.
    task automatic step();
        logic [3:0] acc;
        int         lane;
        acc = inValid & inReady;
        if (sb_on) begin
            for (int l = 0; l < 4; l++) begin
                if (acc[l]) begin
                    exp_d[l][sb_tail[l]] = inData[l*DATA_W +: DATA_W];
                    sb_tail[l]++;
                    n_acc++;
                end
            end
        end
        @(posedge clk);
        #1;
        if (sb_on && wbEnable) begin
            lane = int'(wbAddr[1:0]);
            n_wr++;
            check("sb_addr_range", wbAddr[4:2], 3'b010);
            if (sb_head[lane] < sb_tail[lane]) begin
                check("sb_data", wbData, exp_d[lane][sb_head[lane]]);
                sb_head[lane]++;
            end else begin
                check("sb_extra_write", 1'b1, 1'b0);
            end
        end
    endtask

    initial begin
        rst_n     = 1'b1;
        inValid   = '0;
        inAddr    = '0;
        inData    = '0;
        queryAddr = '0;
        for (int l = 0; l < 4; l++) begin
            sb_head[l] = 0;
            sb_tail[l] = 0;
        end

        #2 rst_n = 1'b0;
        #1;
        check("rst_wbEnable", wbEnable, 1'b0);
        check("rst_wbAddr", wbAddr, '0);
        check("rst_wbData", wbData, '0);
        check("rst_idle", idle, 1'b1);
        check("rst_inReady", inReady, 4'hF);
        check("rst_pending", pending, 4'h0);
        #13 rst_n = 1'b1;

        // Single result on lane 2
        inValid = 4'b0100;
        set_lane(2, 5'd7, 32'hDEADBEEF);
        step();
        inValid = '0;
        check("single_n1_en", wbEnable, 1'b0);
        check("single_n1_idle", idle, 1'b0);
        step();
        check("single_en", wbEnable, 1'b1);
        check("single_addr", wbAddr, 5'd7);
        check("single_data", wbData, 32'hDEADBEEF);
        step();
        check("single_pulse_end", wbEnable, 1'b0);
        check("single_idle", idle, 1'b1);

        // Pending hazard on lane 3 entry; also leaves rr pointer at 0
        queryAddr = {5'd0, 5'd3, 5'd0, 5'd9};
        #1;
        check("pend_before", pending, 4'h0);
        inValid = 4'b1000;
        set_lane(3, 5'd9, 32'h00000099);
        step();
        inValid = '0;
        check("pend_buffered", pending, PEND_HIT);
        step();
        check("pend_wb_en", wbEnable, 1'b1);
        check("pend_wb_addr", wbAddr, 5'd9);
        check("pend_during_write", pending, PEND_HIT);
        step();
        check("pend_after", pending, 4'h0);
        queryAddr = '0;

        // Two simultaneous bursts, each should drain in lane order 0..3
        for (int b = 0; b < 2; b++) begin
            inValid = 4'hF;
            for (int l = 0; l < 4; l++)
                set_lane(l, 5'(l + 1), 32'hA0 + 32'(b * 16 + l));
            step();
            inValid = '0;
            for (int l = 0; l < 4; l++) begin
                step();
                check("rr_en", wbEnable, 1'b1);
                check("rr_addr", wbAddr, 5'(l + 1));
                check("rr_data", wbData, 32'hA0 + 32'(b * 16 + l));
            end
            step();
            check("rr_done_en", wbEnable, 1'b0);
            check("rr_done_idle", idle, 1'b1);
        end

        // Zero register is consumed without a write
        check("zero_ready", inReady[1], 1'b1);
        inValid = 4'b0010;
        set_lane(1, 5'd0, 32'h12345678);
        step();
        inValid = '0;
        check("zero_idle_n1", idle, 1'b1);
        check("zero_en_n1", wbEnable, 1'b0);
        step();
        check("zero_en_n2", wbEnable, 1'b0);
        check("zero_idle_n2", idle, 1'b1);

        // Saturate all lanes for DEPTH+2 edges from empty, rr pointer at 0
        begin
            logic [3:0] ready_exp [6];
            ready_exp = '{4'hF, 4'hF, 4'hF, 4'b0111, 4'b1000, 4'b0001};
            sb_on   = 1'b1;
            inValid = 4'hF;
            for (int c = 0; c < DEPTH + 2; c++) begin
                for (int l = 0; l < 4; l++)
                    set_lane(l, 5'(8 + l), {4'(l), 28'(c)});
                step();
                check("full_ready", inReady, ready_exp[c]);
            end
            inValid = '0;
            for (int i = 0; i < 40 && !idle; i++)
                step();
            check("full_drain_idle", idle, 1'b1);
            check("full_accepts", 32'(n_acc), 32'd20);
            check("full_writes", 32'(n_wr), 32'd20);
            sb_on = 1'b0;
        end

        // Asynchronous reset with three entries still buffered
        inValid = 4'hF;
        for (int l = 0; l < 4; l++)
            set_lane(l, 5'(l + 1), 32'hC0 + 32'(l));
        step();
        inValid = '0;
        step();
        check("arst_pre_en", wbEnable, 1'b1);
        check("arst_pre_idle", idle, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_en", wbEnable, 1'b0);
        check("arst_ready", inReady, 4'hF);
        check("arst_idle", idle, 1'b1);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("arst_no_stale", wbEnable, 1'b0);
        end
        check("arst_idle_end", idle, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_commit_queue.md
Name: wb_commit_queue

Overview:
- Writeback stage directly upstream of the 4-read/4-write register file.
- Collects results from 4 execution lanes, each with a valid/ready handshake, and buffers them in per-lane FIFOs.
- Round-robin arbitration drains them at one register write per cycle. This matches the register file, which honours only one write per clock (priority-encoded enables).
- Output drives the register file's write port 0 (writeEnable0/write0/dataIn0).

Parameters:
DEPTH, 4, entries per lane FIFO; power of 2, minimum 2
ADDR_W, 5, register index width
DATA_W, 32, result data width

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
inValid  input  4  per-lane result valid, bit i = lane i
inReady  output  4  per-lane FIFO can accept, bit i = lane i
inAddr  input  4*ADDR_W  per-lane destination register, lane i at [i*ADDR_W +: ADDR_W]
inData  input  4*DATA_W  per-lane result, lane i at [i*DATA_W +: DATA_W]
wbEnable  output  1  register write strobe, to writeEnable0
wbAddr  output  ADDR_W  register index, to write0
wbData  output  DATA_W  write data, to dataIn0
idle  output  1  all FIFOs empty and wbEnable low
queryAddr  input  4*ADDR_W  register-read addresses, WB_PENDING_EN only
pending  output  4  per-query hazard flag, WB_PENDING_EN only

Behaviour:
- Reset (rst_n low, asynchronous):
  - All FIFO pointers and counts cleared; rrPtr=0.
  - wbEnable=0, wbAddr=0, wbData=0, idle=1, inReady=4'hF, pending=0.
  - Reset mid-operation discards all buffered entries.
- Accept: lane i handshakes when inValid[i] & inReady[i].
  - inReady[i] = (count[i] != DEPTH), derived from registered count only.
  - No push into a full FIFO even if it pops the same cycle. No combinational path from pop to ready.
- Zero register: an accepted entry with inAddr lane value 0 is consumed but not stored; count unchanged.
- FIFO: per-lane, in-order.
  - Pointers wrap modulo DEPTH; count is 0..DEPTH.
  - Simultaneous push and pop on a non-full, non-empty FIFO keeps count unchanged.
- Arbitration, each cycle:
  - Scan lanes rrPtr, rrPtr+1, ..., rrPtr+3 (mod 4); grant the first lane with count != 0.
  - Pop that lane's head entry.
  - rrPtr <= (granted+1) mod 4. If no grant, rrPtr holds.
- Output register: on a grant, at the next edge wbEnable<=1 and wbAddr/wbData <= head entry.
  - With no grant: wbEnable<=0, wbAddr/wbData hold their previous values.
  - wbEnable is high for exactly one cycle per write.
- Latency: push at edge N (FIFO empty, lane wins arbitration) -> wbEnable high after edge N+1. The register file captures at edge N+2.
- Throughput: one write per cycle sustained while any FIFO is non-empty.
- Ordering:
  - Order is preserved within a lane.
  - Across lanes, order follows round-robin only. Producers must not have two in-flight results to the same register on different lanes.
- idle = (all counts == 0) & ~wbEnable, registered-state derived.

Optional Feature:
- Macro WB_PENDING_EN.
- Defined:
  - pending[j] = 1 when queryAddr j is nonzero and matches any valid FIFO entry in any lane, or matches wbAddr while wbEnable=1.
  - Combinational from queryAddr and registered state. The issue stage uses it to stall reads of not-yet-written registers.
- Not defined:
  - queryAddr is ignored.
  - pending is tied to 4'b0000 and no compare logic is synthesized.

Test Plan:
- Single result: lane 2 pushes addr=7, data=0xDEADBEEF from idle -> wbEnable=1, wbAddr=7, wbData=0xDEADBEEF exactly one cycle, two edges after the push; idle then returns to 1.
- Round-robin fairness: all 4 lanes push addr=1..4 in the same cycle with rrPtr=0 -> four consecutive writes in lane order 0,1,2,3; next simultaneous burst after rrPtr=0 again also starts at lane 0.
- Full/backpressure: hold lane 0 valid for DEPTH+2 cycles while lanes 1-3 saturate -> inReady[0] drops when count reaches 4; no entry lost or duplicated; write sequence matches accept order per lane.
- Zero register: lane 1 pushes addr=0, data=0x12345678 -> handshake completes, no wbEnable pulse, idle stays 1.
- Async reset mid-burst: assert rst_n low between edges with 3 entries buffered -> wbEnable=0 and inReady=4'hF immediately; after release, no stale writes appear.
- WB_PENDING_EN: buffer addr=9 in lane 3, queryAddr lane 0=9, lane 1=0 -> pending=4'b0001 until the write pulse's cycle ends, then 0.
